// File: rtl/splitter_pkg.sv
// Shared types and default widths for the word splitter family.
package splitter_pkg;
  localparam int WORD_W_DEF  = 32;
  localparam int SLICE_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
endpackage

// File: rtl/splitter_if.sv
// Producer-side and consumer-side handshakes of the splitter in one bundle.
interface splitter_if
  import splitter_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int SLICE_W = SLICE_W_DEF
);
  localparam int NSLICE = WORD_W / SLICE_W;
  localparam int IDX_W  = $clog2(NSLICE);

  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_word;
  logic               out_valid;
  logic               out_ready;
  logic [SLICE_W-1:0] out_slice;
  logic [IDX_W-1:0]   out_idx;
  logic               out_last;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_slice, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_slice, out_idx, out_last
  );
endinterface

// File: rtl/splitter_slice_mux.sv
// Combinational pick of one SLICE_W field out of a WORD_W word; idx 0 is the LS slice.
module splitter_slice_mux #(
  parameter int WORD_W  = 32,
  parameter int SLICE_W = 8,
  parameter int NSLICE  = WORD_W / SLICE_W,
  parameter int IDX_W   = $clog2(NSLICE)
) (
  input  logic [WORD_W-1:0]  i_word,
  input  logic [IDX_W-1:0]   i_idx,
  output logic [SLICE_W-1:0] o_slice
);
  // Explicit compare loop keeps out-of-range indices (non power-of-2 NSLICE) at zero.
  always_comb begin
    o_slice = '0;
    for (int i = 0; i < NSLICE; i++)
      if (i_idx == IDX_W'(i)) o_slice = i_word[i*SLICE_W +: SLICE_W];
  end
endmodule

// File: rtl/splitter_seq.sv
// Holds one word and streams its slices out one per accepted output handshake.
// Optional feature macro: SPLITTER_SEQ_PARITY_EN adds out_parity (even parity of out_slice).
module splitter_seq
  import splitter_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int SLICE_W   = SLICE_W_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  splitter_if.slave bus,
  output logic      busy
`ifdef SPLITTER_SEQ_PARITY_EN
  ,
  output logic      out_parity
`endif
);
  localparam int NSLICE = WORD_W / SLICE_W;
  localparam int IDX_W  = $clog2(NSLICE);

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_cnt, w_cnt_nxt;
  logic [WORD_W-1:0] r_hold, w_hold_nxt;
  logic [IDX_W-1:0]  w_idx;
  logic              w_last, w_in_xfer, w_out_xfer;

  assign w_last     = (r_state == SEND) && (r_cnt == IDX_W'(NSLICE-1));
  assign w_out_xfer = bus.out_valid && bus.out_ready;
  // Refill on the last slice lets back-to-back words run without a bubble.
  assign bus.in_ready = (r_state == IDLE) || (w_out_xfer && w_last);
  assign w_in_xfer  = bus.in_valid && bus.in_ready;
  assign w_idx      = MSB_FIRST ? (IDX_W'(NSLICE-1) - r_cnt) : r_cnt;

  assign bus.out_valid = (r_state == SEND);
  assign bus.out_idx   = w_idx;
  assign bus.out_last  = w_last;
  assign busy          = (r_state == SEND);

  splitter_slice_mux #(.WORD_W(WORD_W), .SLICE_W(SLICE_W)) u_mux (
    .i_word  (r_hold),
    .i_idx   (w_idx),
    .o_slice (bus.out_slice)
  );

`ifdef SPLITTER_SEQ_PARITY_EN
  assign out_parity = (r_state == SEND) && (^bus.out_slice);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    unique case (r_state)
      IDLE: if (w_in_xfer) begin
        w_state_nxt = SEND;
        w_cnt_nxt   = '0;
        w_hold_nxt  = bus.in_word;
      end
      SEND: if (w_out_xfer) begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (w_in_xfer) w_hold_nxt  = bus.in_word;
          else           w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_splitter_seq.sv
// Scoreboard bench: MSB-first and LSB-first instances share stimulus; expected slices queued per accepted word.
module tb_splitter_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_word = '0;
  logic        out_ready = 1'b1;
  logic        busy_m, busy_l, par_m, par_l;
  bit          rnd_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] slice;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  exp_t       q0[$], q1[$];
  logic [7:0] obs0[$], obs1[$];

  always #5 clk = ~clk;

  splitter_if #(.WORD_W(32), .SLICE_W(8)) if_m ();
  splitter_if #(.WORD_W(32), .SLICE_W(8)) if_l ();

  assign if_m.in_valid  = in_valid;
  assign if_m.in_word   = in_word;
  assign if_m.out_ready = out_ready;
  assign if_l.in_valid  = in_valid;
  assign if_l.in_word   = in_word;
  assign if_l.out_ready = out_ready;

  splitter_seq #(.WORD_W(32), .SLICE_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .bus(if_m.slave), .busy(busy_m)
`ifdef SPLITTER_SEQ_PARITY_EN
    , .out_parity(par_m)
`endif
  );

  splitter_seq #(.WORD_W(32), .SLICE_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .bus(if_l.slave), .busy(busy_l)
`ifdef SPLITTER_SEQ_PARITY_EN
    , .out_parity(par_l)
`endif
  );

`ifndef SPLITTER_SEQ_PARITY_EN
  assign par_m = 1'b0;
  assign par_l = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word expands into NSLICE (slice, idx, last) records in emission order.
  task automatic push_word(input int d, input logic [31:0] w);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.idx   = (d == 0) ? 2'(3 - k) : 2'(k);
      e.slice = 8'(w >> (8 * int'(e.idx)));
      e.last  = (k == 3);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic check_dut(input int d, input logic ir, input logic ov, input logic [7:0] sl,
                           input logic [1:0] ix, input logic ls, input logic bz, input logic par);
    int   sz;
    exp_t e;
    logic exp_ir;
    sz     = (d == 0) ? q0.size() : q1.size();
    exp_ir = (sz == 0) || (out_ready && sz == 1);
    chk($sformatf("d%0d in_ready", d), 32'(ir), 32'(exp_ir));
    chk($sformatf("d%0d out_valid", d), 32'(ov), 32'(sz > 0));
    chk($sformatf("d%0d busy", d), 32'(bz), 32'(sz > 0));
    if (sz == 0) begin
      chk($sformatf("d%0d idle_last", d), 32'(ls), 32'd0);
`ifdef SPLITTER_SEQ_PARITY_EN
      chk($sformatf("d%0d idle_parity", d), 32'(par), 32'd0);
`endif
    end else begin
      e = (d == 0) ? q0[0] : q1[0];
      chk($sformatf("d%0d slice", d), 32'(sl), 32'(e.slice));
      chk($sformatf("d%0d idx", d), 32'(ix), 32'(e.idx));
      chk($sformatf("d%0d last", d), 32'(ls), 32'(e.last));
`ifdef SPLITTER_SEQ_PARITY_EN
      chk($sformatf("d%0d parity", d), 32'(par), 32'(^e.slice));
`endif
      if (out_ready) begin
        if (d == 0) begin void'(q0.pop_front()); obs0.push_back(sl); end
        else        begin void'(q1.pop_front()); obs1.push_back(sl); end
      end
    end
    if (in_valid && exp_ir) push_word(d, in_word);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      check_dut(0, if_m.in_ready, if_m.out_valid, if_m.out_slice, if_m.out_idx, if_m.out_last, busy_m, par_m);
      check_dut(1, if_l.in_ready, if_l.out_valid, if_l.out_slice, if_l.out_idx, if_l.out_last, busy_l, par_l);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_word  = w;
    forever begin
      @(negedge clk);
      if (if_m.in_ready) break;
      if (++n > 200) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: in_ready stuck at 0, required 1");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_word  = $urandom;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_seq(input string name, input int d, input logic [31:0] exp);
    logic [31:0] e;
    e = exp;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a;
      a = (d == 0) ? ((obs0.size() > i) ? obs0[i] : 8'hxx) : ((obs1.size() > i) ? obs1[i] : 8'hxx);
      chk($sformatf("%s[%0d]", name, i), 32'(a), 32'(e[31-8*i -: 8]));
    end
  endtask

  initial begin
    int n;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // Basic ordering in both directions
    obs0.delete(); obs1.delete();
    out_ready = 1'b1;
    send(32'h12345678);
    cyc(5);
    chk_seq("msb_order", 0, 32'h12345678);
    chk_seq("lsb_order", 1, 32'h78563412);

    // Stall on slice 34 for three cycles
    send(32'h12345678);
    cyc(1);
    out_ready = 1'b0;
    cyc(3);
    out_ready = 1'b1;
    cyc(5);

    // Back-to-back words with in_valid held
    obs0.delete(); obs1.delete();
    send(32'hAABBCCDD);
    send(32'h11223344);
    cyc(5);
    chk_seq("b2b_w0", 0, 32'hAABBCCDD);
    obs0 = obs0[4:$];
    chk_seq("b2b_w1", 0, 32'h11223344);

    // Reset while slice 56 is showing
    send(32'h12345678);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    obs0.delete();
    send(32'hA5C3F00F);
    cyc(5);
    chk_seq("post_reset", 0, 32'hA5C3F00F);

    // Parity reference word
    send(32'h07FF0100);
    cyc(5);

    // Random traffic with random back-pressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'b0;
      cyc($urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0);
      send($urandom);
    end
    rnd_ready = 1'b0;
    #1 out_ready = 1'b1;

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin cyc(1); n++; end
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d slices outstanding, required 0", q0.size(), q1.size());
    end
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/splitter_seq.md
# splitter_seq

Sequencer for the word splitter datapath: accepts one WORD_W-bit word over a valid/ready handshake, holds it in a register, and emits its SLICE_W-bit fields one per cycle over a second valid/ready handshake. It sits between a word producer, such as an instruction or data register, and a narrow consumer, such as a byte bus or display driver. It owns all sequencing: holding, slice indexing, back-pressure and end-of-word marking.

## Interface
Parameters:
- WORD_W, default 32: input word width; must be a multiple of SLICE_W.
- SLICE_W, default 8: output slice width.
- MSB_FIRST, default 1: 1 emits the most-significant slice first; 0 emits the least-significant slice first.
- Derived constant NSLICE = WORD_W/SLICE_W, which must be ≥2. IDX_W = $clog2(NSLICE).

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: producer offers in_word.
- in_ready, output, 1: block can accept a word this cycle.
- in_word, input, WORD_W: word to split.
- out_valid, output, 1: out_slice is valid.
- out_ready, input, 1: consumer accepts the slice this cycle.
- out_slice, output, SLICE_W: current slice.
- out_idx, output, IDX_W: position of the current slice in the word. 0 is the least-significant slice, regardless of MSB_FIRST.
- out_last, output, 1: the current slice is the final slice of the word.
- busy, output, 1: a word is held (state SEND).

## Operation
- FSM states:
  - IDLE: no word held.
  - SEND: word held; slices are emitted.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Transitions:
  - IDLE → SEND on an input transfer. The word is latched into hold_q and the slice counter cnt_q is set to 0.
  - In SEND, each output transfer increments cnt_q.
  - On the output transfer with out_last=1:
    - If an input transfer also occurs that cycle, the new word is latched, cnt_q is set to 0 and the state stays SEND.
    - Otherwise the state goes to IDLE.
- Output decoding:
  - in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - out_valid = (state==SEND).
  - out_idx = MSB_FIRST ? NSLICE-1-cnt_q : cnt_q.
  - out_slice = hold_q[out_idx*SLICE_W +: SLICE_W].
  - out_last = (cnt_q == NSLICE-1).
- While out_valid && !out_ready: out_slice, out_idx and out_last hold stable. in_word is ignored.
- in_word is sampled only on an input transfer. The producer may change it at any other time.
- No slice is skipped or duplicated. Exactly NSLICE output transfers occur per accepted word.

## Timing
- Reset (synchronous, at a clk edge with reset=1):
  - state=IDLE, cnt_q=0, hold_q=0.
  - Outputs: out_valid=0, out_last=0, busy=0, in_ready=1.
  - out_slice and out_idx are not required to hold a defined value while out_valid=0.
- Reset mid-word: the held word is discarded. Outputs are at reset values in the cycle after the edge. No partial completion occurs.
- Latency: a word accepted at edge N has its first slice valid in the cycle following edge N.
- Throughput:
  - With out_ready held at 1, one word is emitted every NSLICE cycles.
  - Back-to-back words have zero bubble cycles.
- A simultaneous last-slice output transfer and input transfer is legal and required; see Operation.
- in_ready is combinational from out_ready. out_valid is registered and does not depend on out_ready.

## Configuration
- Macro: SPLITTER_SEQ_PARITY_EN.
- When defined:
  - Adds output port out_parity, 1 bit, equal to the XOR-reduction of out_slice (even parity).
  - out_parity is valid and stable under the same rules as out_slice.
  - out_parity is 0 while out_valid=0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package splitter_pkg holds:
  - The state typedef (IDLE, SEND).
  - Default constants for WORD_W and SLICE_W.
- Sub-module splitter_slice_mux: combinational selection of slice out_idx from hold_q, parameterised by WORD_W and SLICE_W. It is reused by other splitter consumers.
- The top module contains the FSM, hold_q, cnt_q and the handshake logic.

## Test plan
All scenarios use WORD_W=32 and SLICE_W=8.
- MSB_FIRST=1, in_word=32'h12345678, out_ready=1:
  - out_slice is 12, 34, 56, 78 on four consecutive cycles.
  - out_idx is 3, 2, 1, 0.
  - out_last=1 only on the cycle with 78.
- MSB_FIRST=0, same word:
  - out_slice is 78, 56, 34, 12.
  - out_idx is 0, 1, 2, 3.
- Back-pressure: out_ready=0 for 3 cycles while slice 34 is shown:
  - out_slice stays 34 and in_ready=0 during those cycles.
  - Resuming out_ready gives 56, then 78, with no loss or duplication.
- Back-to-back words 32'hAABBCCDD then 32'h11223344, in_valid=1 continuously, out_ready=1:
  - Eight consecutive valid slices: AA BB CC DD 11 22 33 44.
  - in_ready=1 exactly on the DD cycle.
- Reset asserted on the cycle showing slice 56 of 32'h12345678:
  - The next cycle has out_valid=0, busy=0, in_ready=1.
  - The next word starts cleanly at cnt 0.
- With SPLITTER_SEQ_PARITY_EN defined, word 32'h07FF0100:
  - out_parity is 1, 0, 1, 0 for slices 07, FF, 01, 00.
